// File: rtl/apb5_pkg.sv
// Shared types and helpers for the APB5 memory completer.
// Imported by the top level and its storage sub-module.
package apb5_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OK     = 2'd0,
        DECODE = 2'd1,
        PROT   = 2'd2,
        STRB   = 2'd3
    } err_code_e;

    // Right shift that turns a byte address into a word index.
    function automatic int idx_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb5_mem_completer_if.sv
// APB5 bus bundle shared by requester and completer.
// The master modport drives the request side, the slave modport drives the response.
interface apb5_mem_completer_if #(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int USER_REQ_WIDTH  = 8,
    parameter int USER_DATA_WIDTH = 16,
    parameter int USER_RESP_WIDTH = 8
);
    logic                       PSEL;
    logic                       PENABLE;
    logic [ADDR_WIDTH-1:0]      PADDR;
    logic                       PWRITE;
    logic [DATA_WIDTH-1:0]      PWDATA;
    logic [DATA_WIDTH/8-1:0]    PSTRB;
    logic [2:0]                 PPROT;
    logic                       PNSE;
    logic                       PWAKEUP;
    logic [USER_REQ_WIDTH-1:0]  PAUSER;
    logic [USER_DATA_WIDTH-1:0] PWUSER;
    logic [DATA_WIDTH-1:0]      PRDATA;
    logic                       PREADY;
    logic                       PSLVERR;
    logic [USER_DATA_WIDTH-1:0] PRUSER;
    logic [USER_RESP_WIDTH-1:0] PBUSER;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, PNSE,
               PWAKEUP, PAUSER, PWUSER,
        input  PRDATA, PREADY, PSLVERR, PRUSER, PBUSER
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, PNSE,
               PWAKEUP, PAUSER, PWUSER,
        output PRDATA, PREADY, PSLVERR, PRUSER, PBUSER
    );

endinterface

// File: rtl/apb5_strb_mem.sv
// Word-organised data array plus per-word user array.
// Byte-strobed write, whole-word user write, combinational read, async clear.
module apb5_strb_mem #(
    parameter  int DEPTH      = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int USER_WIDTH = 16,
    localparam int AW         = $clog2(DEPTH),
    localparam int NB         = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [NB-1:0]         wstrb,
    input  logic [USER_WIDTH-1:0] wuser,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [USER_WIDTH-1:0] ruser
);

    logic [DATA_WIDTH-1:0] mem_q  [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d  [DEPTH];
    logic [USER_WIDTH-1:0] umem_q [DEPTH];
    logic [USER_WIDTH-1:0] umem_d [DEPTH];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        mem_d  = mem_q;
        umem_d = umem_q;
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) mem_d[waddr][b*8 +: 8] = wdata[b*8 +: 8];
            end
            umem_d[waddr] = wuser;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is cleared on reset because reads of never-written words must return zero.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i]  <= '0;
                umem_q[i] <= '0;
            end
        end else begin
            mem_q  <= mem_d;
            umem_q <= umem_d;
        end
    end

    assign rdata = mem_q[raddr];
    assign ruser = umem_q[raddr];

endmodule

// File: rtl/apb5_mem_completer.sv
// APB5 completer fronting a word memory: programmable wait states, byte strobes,
// decode/protection/strobe errors, optional RME check and sticky protocol flags.
module apb5_mem_completer
    import apb5_pkg::*;
#(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 32,
    parameter int SECURE_BASE     = 16,
    parameter int WAIT_WIDTH      = 3,
    parameter int RME_SUPPORT     = 1,
    parameter int WAKEUP_SUPPORT  = 1,
    parameter int USER_REQ_WIDTH  = 8,
    parameter int USER_DATA_WIDTH = 16,
    parameter int USER_RESP_WIDTH = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    apb5_mem_completer_if.slave   apb,
    input  logic [WAIT_WIDTH-1:0] wait_cfg,
    output logic                  proto_err,
    output logic                  wakeup_err
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int SHIFT = idx_shift(DATA_WIDTH);
    localparam int AW    = $clog2(DEPTH);

    state_e                state_q, state_d;
    logic [WAIT_WIDTH-1:0] cnt_q, cnt_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  write_q, write_d;
    logic [NB-1:0]         strb_q, strb_d;
    err_code_e             err_q, err_d;
    logic                  proto_err_q, proto_err_d;
    logic                  wakeup_err_q, wakeup_err_d;

    logic [ADDR_WIDTH-1:0]      setup_idx;
    err_code_e                  setup_err;
    logic                       mem_we;
    logic                       pready;
    logic [DATA_WIDTH-1:0]      mem_rdata;
    logic [USER_DATA_WIDTH-1:0] mem_ruser;
    logic                       unused_pauser;

    assign unused_pauser = ^apb.PAUSER;

    // The full-width index is kept for decode so out-of-range addresses never alias.
    assign setup_idx = apb.PADDR >> SHIFT;

    always_comb begin
        setup_err = OK;
        if (32'(setup_idx) >= DEPTH) begin
            setup_err = DECODE;
        end else if (32'(setup_idx) >= SECURE_BASE &&
                     (apb.PPROT[1] || ((RME_SUPPORT != 0) && apb.PNSE))) begin
            setup_err = PROT;
        end else if (!apb.PWRITE && apb.PSTRB != '0) begin
            setup_err = STRB;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            paddr_q      <= '0;
            write_q      <= 1'b0;
            strb_q       <= '0;
            err_q        <= OK;
            proto_err_q  <= 1'b0;
            wakeup_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            paddr_q      <= paddr_d;
            write_q      <= write_d;
            strb_q       <= strb_d;
            err_q        <= err_d;
            proto_err_q  <= proto_err_d;
            wakeup_err_q <= wakeup_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        paddr_d      = paddr_q;
        write_d      = write_q;
        strb_d       = strb_q;
        err_d        = err_q;
        proto_err_d  = proto_err_q;
        wakeup_err_d = wakeup_err_q;
        mem_we       = 1'b0;

        if ((WAKEUP_SUPPORT != 0) && apb.PSEL && !apb.PWAKEUP) wakeup_err_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (apb.PENABLE) begin
                    proto_err_d = 1'b1;
                end else if (apb.PSEL) begin
                    state_d = ACCESS;
                    cnt_d   = wait_cfg;
                    idx_d   = setup_idx[AW-1:0];
                    paddr_d = apb.PADDR;
                    write_d = apb.PWRITE;
                    strb_d  = apb.PSTRB;
                    err_d   = setup_err;
                end
            end
            ACCESS: begin
                if (!apb.PSEL) begin
                    // Abandoned transfer: flag it and drop back without touching memory.
                    proto_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    if (apb.PADDR != paddr_q || apb.PWRITE != write_q || apb.PSTRB != strb_q) begin
                        proto_err_d = 1'b1;
                    end
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - WAIT_WIDTH'(1);
                    end else if (apb.PENABLE) begin
                        state_d = IDLE;
                        mem_we  = write_q && (err_q == OK);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response is a pure function of registered state, so it never depends on live bus inputs.
    always_comb begin
        pready      = (state_q == ACCESS) && (cnt_q == '0);
        apb.PREADY  = pready;
        apb.PSLVERR = pready && (err_q != OK);
        apb.PBUSER  = pready ? USER_RESP_WIDTH'(err_q) : '0;
        apb.PRDATA  = '0;
        apb.PRUSER  = '0;
        if (pready && !write_q && err_q == OK) begin
            apb.PRDATA = mem_rdata;
            apb.PRUSER = mem_ruser;
        end
    end

    assign proto_err  = proto_err_q;
    assign wakeup_err = wakeup_err_q;

    apb5_strb_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .USER_WIDTH (USER_DATA_WIDTH)
    ) u_mem (
        .clk   (PCLK),
        .rst_n (PRESETN),
        .we    (mem_we),
        .waddr (idx_q),
        .wdata (apb.PWDATA),
        .wstrb (strb_q),
        .wuser (apb.PWUSER),
        .raddr (idx_q),
        .rdata (mem_rdata),
        .ruser (mem_ruser)
    );

endmodule

// File: tb/tb_apb5_mem_completer.sv
// Directed bench for apb5_mem_completer: a table of back-to-back transfers with
// hand-computed responses, then sequences for aborts, wakeup, PADDR change and reset.
module tb_apb5_mem_completer;

    logic       PCLK;
    logic       PRESETN;
    logic [2:0] wait_cfg;
    logic       proto_err;
    logic       wakeup_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int done_cyc = 0;

    apb5_mem_completer_if apb ();

    apb5_mem_completer dut (
        .PCLK       (PCLK),
        .PRESETN    (PRESETN),
        .apb        (apb.slave),
        .wait_cfg   (wait_cfg),
        .proto_err  (proto_err),
        .wakeup_err (wakeup_err)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic        nse;
        logic [15:0] wuser;
        int          waits;
        logic [31:0] rdata;
        logic [15:0] ruser;
        logic        slverr;
        logic [7:0]  buser;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] addr, input logic wr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [2:0] prot, input logic nse,
                                input logic [15:0] wuser, input int waits, input logic [31:0] rdata,
                                input logic [15:0] ruser, input logic slverr, input logic [7:0] buser);
        vec_t v;
        v.addr = addr; v.wr = wr; v.wdata = wdata; v.strb = strb; v.prot = prot; v.nse = nse;
        v.wuser = wuser; v.waits = waits; v.rdata = rdata; v.ruser = ruser; v.slverr = slverr;
        v.buser = buser;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Drives one full transfer starting in the current cycle; leaves the bus idle one step past completion.
    task automatic xfer(input vec_t v, output logic [31:0] rdata, output logic [15:0] ruser,
                        output logic slverr, output logic [7:0] buser, output int waits);
        wait_cfg    = 3'(v.waits);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PADDR   = v.addr;
        apb.PWRITE  = v.wr;
        apb.PWDATA  = v.wdata;
        apb.PSTRB   = v.strb;
        apb.PPROT   = v.prot;
        apb.PNSE    = v.nse;
        apb.PWUSER  = v.wuser;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        waits = 0;
        while (!apb.PREADY && waits < 20) begin
            @(posedge PCLK); #1;
            waits++;
        end
        rdata  = apb.PRDATA;
        ruser  = apb.PRUSER;
        slverr = apb.PSLVERR;
        buser  = apb.PBUSER;
        @(posedge PCLK); #1;
        done_cyc    = cyc;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        logic [31:0] rd;
        logic [15:0] ru;
        logic        se;
        logic [7:0]  bu;
        int          w;
        xfer(v, rd, ru, se, bu, w);
        check({name, " rdata"},  64'(rd), 64'(v.rdata));
        check({name, " ruser"},  64'(ru), 64'(v.ruser));
        check({name, " pslverr"}, 64'(se), 64'(v.slverr));
        check({name, " pbuser"}, 64'(bu), 64'(v.buser));
        check({name, " waits"},  64'(w),  64'(v.waits));
    endtask

    initial begin
        int prev_done;

        PRESETN     = 1'b1;
        wait_cfg    = '0;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PADDR   = '0;
        apb.PWRITE  = 1'b0;
        apb.PWDATA  = '0;
        apb.PSTRB   = '0;
        apb.PPROT   = '0;
        apb.PNSE    = 1'b0;
        apb.PWAKEUP = 1'b1;
        apb.PAUSER  = '0;
        apb.PWUSER  = '0;
        #1 PRESETN = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESETN = 1'b1;

        check("reset pready",     64'(apb.PREADY),  64'd0);
        check("reset pslverr",    64'(apb.PSLVERR), 64'd0);
        check("reset prdata",     64'(apb.PRDATA),  64'd0);
        check("reset pruser",     64'(apb.PRUSER),  64'd0);
        check("reset pbuser",     64'(apb.PBUSER),  64'd0);
        check("reset proto_err",  64'(proto_err),   64'd0);
        check("reset wakeup_err", 64'(wakeup_err),  64'd0);

        //                addr  wr  wdata         strb  prot  nse wuser     w  rdata         ruser     se  bu
        vecs.push_back(mk(8'h04, 1, 32'hA5A5_1234, 4'hF, 3'b000, 0, 16'h00BE, 0, 32'h0,         16'h0,    0, 8'd0));
        vecs.push_back(mk(8'h04, 0, 32'h0,         4'h0, 3'b000, 0, 16'h0,    0, 32'hA5A5_1234, 16'h00BE, 0, 8'd0));
        vecs.push_back(mk(8'h04, 0, 32'h0,         4'h0, 3'b000, 0, 16'h0,    3, 32'hA5A5_1234, 16'h00BE, 0, 8'd0));
        vecs.push_back(mk(8'h08, 1, 32'hFFFF_FFFF, 4'hF, 3'b000, 0, 16'h1111, 0, 32'h0,         16'h0,    0, 8'd0));
        vecs.push_back(mk(8'h08, 1, 32'h1122_3344, 4'h5, 3'b000, 0, 16'h2222, 1, 32'h0,         16'h0,    0, 8'd0));
        vecs.push_back(mk(8'h08, 0, 32'h0,         4'h0, 3'b000, 0, 16'h0,    0, 32'hFF22_FF44, 16'h2222, 0, 8'd0));
        vecs.push_back(mk(8'h80, 0, 32'h0,         4'h0, 3'b000, 0, 16'h0,    0, 32'h0,         16'h0,    1, 8'd1));
        vecs.push_back(mk(8'h04, 0, 32'h0,         4'h1, 3'b000, 0, 16'h0,    0, 32'h0,         16'h0,    1, 8'd3));
        vecs.push_back(mk(8'h80, 0, 32'h0,         4'hF, 3'b010, 0, 16'h0,    2, 32'h0,         16'h0,    1, 8'd1));
        vecs.push_back(mk(8'h50, 1, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 16'h0ABC, 0, 32'h0,         16'h0,    1, 8'd2));
        vecs.push_back(mk(8'h50, 1, 32'hDEAD_BEEF, 4'hF, 3'b000, 1, 16'h0ABC, 0, 32'h0,         16'h0,    1, 8'd2));
        vecs.push_back(mk(8'h50, 0, 32'h0,         4'h0, 3'b000, 0, 16'h0,    0, 32'h0,         16'h0,    0, 8'd0));
        vecs.push_back(mk(8'h50, 1, 32'hCAFE_F00D, 4'hF, 3'b000, 0, 16'h0055, 0, 32'h0,         16'h0,    0, 8'd0));
        vecs.push_back(mk(8'h50, 0, 32'h0,         4'h1, 3'b010, 0, 16'h0,    0, 32'h0,         16'h0,    1, 8'd2));
        vecs.push_back(mk(8'h50, 0, 32'h0,         4'h0, 3'b000, 0, 16'h0,    0, 32'hCAFE_F00D, 16'h0055, 0, 8'd0));
        vecs.push_back(mk(8'h3C, 0, 32'h0,         4'h0, 3'b010, 1, 16'h0,    0, 32'h0,         16'h0,    0, 8'd0));
        vecs.push_back(mk(8'h06, 1, 32'h0BAD_C0DE, 4'hF, 3'b000, 0, 16'h0777, 2, 32'h0,         16'h0,    0, 8'd0));
        vecs.push_back(mk(8'h04, 0, 32'h0,         4'h0, 3'b000, 0, 16'h0,    0, 32'h0BAD_C0DE, 16'h0777, 0, 8'd0));
        vecs.push_back(mk(8'h7C, 0, 32'h0,         4'h0, 3'b000, 0, 16'h0,    0, 32'h0,         16'h0,    0, 8'd0));
        vecs.push_back(mk(8'hFC, 0, 32'h0,         4'h0, 3'b000, 0, 16'h0,    0, 32'h0,         16'h0,    1, 8'd1));
        vecs.push_back(mk(8'h10, 1, 32'h1234_5678, 4'h0, 3'b000, 0, 16'h00AA, 0, 32'h0,         16'h0,    0, 8'd0));
        vecs.push_back(mk(8'h10, 0, 32'h0,         4'h0, 3'b000, 0, 16'h0,    0, 32'h0,         16'h00AA, 0, 8'd0));

        // Table runs back-to-back: completion-to-completion spacing must be setup + waits + access.
        prev_done = 0;
        foreach (vecs[i]) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
            if (i > 0) check($sformatf("v%0d gap", i), 64'(done_cyc - prev_done), 64'(2 + vecs[i].waits));
            prev_done = done_cyc;
        end
        check("table proto_err",  64'(proto_err),  64'd0);
        check("table wakeup_err", 64'(wakeup_err), 64'd0);

        // PSEL dropped during wait states: aborted write must leave idx 3 untouched.
        wait_cfg    = 3'd3;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PADDR   = 8'h0C;
        apb.PWRITE  = 1'b1;
        apb.PWDATA  = 32'h0000_0055;
        apb.PSTRB   = 4'hF;
        apb.PPROT   = 3'b000;
        apb.PNSE    = 1'b0;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        @(posedge PCLK); #1;
        check("abort proto_err", 64'(proto_err),  64'd1);
        check("abort pready",    64'(apb.PREADY), 64'd0);
        run_vec("abort readback", mk(8'h0C, 0, 32'h0, 4'h0, 3'b000, 0, 16'h0, 0, 32'h0, 16'h0, 0, 8'd0));

        apb.PWAKEUP = 1'b0;
        run_vec("nowake", mk(8'h08, 0, 32'h0, 4'h0, 3'b000, 0, 16'h0, 0, 32'hFF22_FF44, 16'h2222, 0, 8'd0));
        apb.PWAKEUP = 1'b1;
        check("wakeup_err set", 64'(wakeup_err), 64'd1);

        // Reset while the completer is presenting read data.
        wait_cfg    = 3'd0;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PADDR   = 8'h08;
        apb.PWRITE  = 1'b0;
        apb.PSTRB   = 4'h0;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        check("pre-reset prdata", 64'(apb.PRDATA), 64'hFF22_FF44);
        PRESETN = 1'b0;
        #1;
        check("midreset pready",     64'(apb.PREADY),  64'd0);
        check("midreset prdata",     64'(apb.PRDATA),  64'd0);
        check("midreset pruser",     64'(apb.PRUSER),  64'd0);
        check("midreset pslverr",    64'(apb.PSLVERR), 64'd0);
        check("midreset pbuser",     64'(apb.PBUSER),  64'd0);
        check("midreset proto_err",  64'(proto_err),   64'd0);
        check("midreset wakeup_err", 64'(wakeup_err),  64'd0);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETN = 1'b1;
        run_vec("cleared idx2",  mk(8'h08, 0, 32'h0, 4'h0, 3'b000, 0, 16'h0, 0, 32'h0, 16'h0, 0, 8'd0));
        run_vec("cleared idx20", mk(8'h50, 0, 32'h0, 4'h0, 3'b000, 0, 16'h0, 1, 32'h0, 16'h0, 0, 8'd0));
        check("post-reset proto_err", 64'(proto_err), 64'd0);

        // PADDR moves during wait states.
        wait_cfg    = 3'd2;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PADDR   = 8'h04;
        apb.PWRITE  = 1'b0;
        apb.PSTRB   = 4'h0;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        apb.PADDR   = 8'h08;
        @(posedge PCLK); #1;
        check("paddr change proto_err", 64'(proto_err), 64'd1);
        for (int k = 0; k < 20 && !apb.PREADY; k++) begin
            @(posedge PCLK); #1;
        end
        check("paddr change completes", 64'(apb.PREADY), 64'd1);
        @(posedge PCLK); #1;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;

        // PENABLE seen while idle.
        PRESETN = 1'b0;
        #1 PRESETN = 1'b1;
        check("rearm proto_err", 64'(proto_err), 64'd0);
        apb.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b0;
        check("idle penable proto_err", 64'(proto_err), 64'd1);
        check("idle penable pready",    64'(apb.PREADY), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
